// File: rtl/fetch_ctrl_if.sv
// Bundle between the fetch sequencer, the IF/ID pipeline and the instruction memory.
// master = fetch_ctrl side, slave = pipeline/memory side.
interface fetch_ctrl_if;
  logic [31:0] PCF;
  logic        PCSrcD;
  logic        StallD;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemAck;
  logic        MemRValid;
  logic [31:0] MemRData;
  logic        StallF;
  logic [31:0] InstrF;
  logic        InstrValidF;
  logic        FetchErr;

  modport master (
    input  PCF, PCSrcD, StallD, MemAck, MemRValid, MemRData,
    output MemReq, MemAddr, StallF, InstrF, InstrValidF, FetchErr
  );

  modport slave (
    output PCF, PCSrcD, StallD, MemAck, MemRValid, MemRData,
    input  MemReq, MemAddr, StallF, InstrF, InstrValidF, FetchErr
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Single-outstanding fetch sequencer: holds the IF PC until the instruction for PCF returns,
// drops responses made stale by a Decode redirect, and latches a sticky memory timeout.
module fetch_ctrl #(
  parameter int          TIMEOUT = 64,
  parameter logic [31:0] NOP     = 32'h00000000
) (
  input  logic          clk,
  input  logic          reset,
  fetch_ctrl_if.master  bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] FLUSH = 3'd4;
  localparam logic [2:0] ERR   = 3'd5;

  logic [2:0]    state;
  logic          kill;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [31:0]   addr_q;
  logic          addr_load;
  logic [31:0]   pc_word;
  logic          kill_now;

  assign pc_word   = bus.PCF & 32'hFFFF_FFFC;
  assign kill_now  = kill | bus.PCSrcD;
  assign count_nxt = count + CW'(1);

  // After DONE/FLUSH the PC only settles on the edge that enters REQ, so the first REQ
  // cycle forwards PCF directly and captures it; later REQ cycles replay the capture.
  assign bus.MemReq  = (state == REQ);
  assign bus.MemAddr = (state == REQ && addr_load) ? pc_word : addr_q;

  always_comb begin
    bus.StallF = 1'b1;
    case (state)
      DONE:    bus.StallF = bus.StallD;
      FLUSH:   bus.StallF = 1'b0;
      default: bus.StallF = 1'b1;
    endcase
    if (reset) bus.StallF = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      kill            <= 1'b0;
      count           <= '0;
      addr_q          <= '0;
      addr_load       <= 1'b0;
      bus.InstrF      <= NOP;
      bus.InstrValidF <= 1'b0;
      bus.FetchErr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          addr_q <= pc_word;
          state  <= REQ;
        end

        REQ: begin
          if (addr_load) begin
            addr_q    <= pc_word;
            addr_load <= 1'b0;
          end
          if (bus.PCSrcD) kill <= 1'b1;
          if (bus.MemAck) begin
            count <= '0;
            state <= WAIT;
          end
        end

        WAIT: begin
          if (bus.MemRValid) begin
            // A redirect coinciding with the response still makes that response stale.
            if (kill_now) begin
              kill  <= 1'b0;
              state <= FLUSH;
            end else begin
              bus.InstrF      <= bus.MemRData;
              bus.InstrValidF <= 1'b1;
              state           <= DONE;
            end
          end else begin
            if (bus.PCSrcD) kill <= 1'b1;
            count <= count_nxt;
            if (count_nxt == CW'(TIMEOUT)) begin
              bus.FetchErr <= 1'b1;
              state        <= ERR;
            end
          end
        end

        DONE: begin
          if (!bus.StallD) begin
            bus.InstrF      <= NOP;
            bus.InstrValidF <= 1'b0;
            addr_load       <= 1'b1;
            state           <= REQ;
          end
        end

        FLUSH: begin
          addr_load <= 1'b1;
          state     <= REQ;
        end

        ERR: begin
          state <= ERR;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
